// File: rtl/esm_dispatch_buffer.sv
// Slot-based entry buffer: allocates the lowest free slot per accepted entry, announces
// the slot index on a ready stream, and releases the slot selected by the core.
module esm_dispatch_buffer #(
    parameter int bs = 16,
    parameter int dw = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [dw-1:0]      in_data,
    output logic               in_ready,
    output logic               ready_valid,
    output logic [$clog2(bs)-1:0] ready_index,
    input  logic               sel_valid,
    input  logic [$clog2(bs)-1:0] sel_index,
    output logic               sel_ready,
    output logic               out_valid,
    output logic [dw-1:0]      out_data,
    input  logic               out_ready,
    output logic [$clog2(bs):0] count,
    output logic               full,
    output logic               empty,
    output logic               sel_err
);
    localparam int bs_bits = $clog2(bs);
    localparam logic [bs_bits:0] full_count = (bs_bits+1)'(bs);
    localparam logic [bs_bits:0] one_count  = (bs_bits+1)'(1);
    localparam logic [bs_bits-1:0] one_ptr  = bs_bits'(1);

    function automatic logic [bs_bits-1:0] lowest_free(input logic [bs-1:0] occ);
        lowest_free = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!occ[i]) lowest_free = bs_bits'(i);
        end
    endfunction

    logic [bs-1:0]      occupied_r;
    logic [dw-1:0]      data_mem_r [bs];
    logic [bs_bits-1:0] fifo_mem_r [bs];
    logic [bs_bits-1:0] fifo_wr_r;
    logic [bs_bits-1:0] fifo_rd_r;
    logic [bs_bits:0]   fifo_cnt_r;
    logic               ready_valid_r;
    logic [bs_bits-1:0] ready_index_r;
    logic               out_valid_r;
    logic [dw-1:0]      out_data_r;
    logic [bs_bits:0]   count_r;
    logic               full_r;
    logic               empty_r;
    logic               sel_err_r;

    logic               accept_s;
    logic [bs_bits-1:0] alloc_s;
    logic               sel_ready_s;
    logic               release_s;
    logic               bad_sel_s;
    logic               fifo_pop_s;
    logic [bs_bits:0]   count_next_s;
    logic [bs_bits:0]   fifo_cnt_next_s;
    logic [bs-1:0]      set_mask_s;
    logic [bs-1:0]      clr_mask_s;

    // Handshake decode; the allocator only ever looks at the pre-edge bitmap.
    always_comb begin
        accept_s    = in_valid & ~full_r;
        alloc_s     = lowest_free(occupied_r);
        sel_ready_s = ~out_valid_r | out_ready;
        release_s   = sel_valid & sel_ready_s & occupied_r[sel_index];
        bad_sel_s   = sel_valid & sel_ready_s & ~occupied_r[sel_index];
        fifo_pop_s  = (fifo_cnt_r != '0);
        set_mask_s  = '0;
        clr_mask_s  = '0;
        if (accept_s) begin
            set_mask_s[alloc_s] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (release_s) begin
            clr_mask_s[sel_index] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
    end

    // Next occupancy and ready-FIFO fill level.
    always_comb begin
        count_next_s    = count_r;
        fifo_cnt_next_s = fifo_cnt_r;
        case ({accept_s, release_s})
            2'b10:   count_next_s = count_r + one_count;
            2'b01:   count_next_s = count_r - one_count;
            default: count_next_s = count_r;
        endcase
        case ({accept_s, fifo_pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + one_count;
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - one_count;
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
    end

    // Payload and index storage (no reset needed: guarded by bitmap and FIFO count).
    always_ff @(posedge clk) begin
        if (accept_s) begin
            data_mem_r[alloc_s]   <= in_data;
            fifo_mem_r[fifo_wr_r] <= alloc_s;
        end
    end

    // Control state, ready stream, output register and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupied_r    <= '0;
            fifo_wr_r     <= '0;
            fifo_rd_r     <= '0;
            fifo_cnt_r    <= '0;
            ready_valid_r <= 1'b0;
            ready_index_r <= '0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            count_r       <= '0;
            full_r        <= 1'b0;
            empty_r       <= 1'b1;
            sel_err_r     <= 1'b0;
        end else begin
            occupied_r <= (occupied_r | set_mask_s) & ~clr_mask_s;
            fifo_cnt_r <= fifo_cnt_next_s;
            count_r    <= count_next_s;
            full_r     <= (count_next_s == full_count);
            empty_r    <= (count_next_s == '0);
            if (accept_s) fifo_wr_r <= fifo_wr_r + one_ptr;
            if (fifo_pop_s) begin
                ready_valid_r <= 1'b1;
                ready_index_r <= fifo_mem_r[fifo_rd_r];
                fifo_rd_r     <= fifo_rd_r + one_ptr;
            end else begin
                ready_valid_r <= 1'b0;
            end
            if (release_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= data_mem_r[sel_index];
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (bad_sel_s) sel_err_r <= 1'b1;
        end
    end

    assign in_ready    = ~full_r;
    assign sel_ready   = sel_ready_s;
    assign ready_valid = ready_valid_r;
    assign ready_index = ready_index_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign sel_err     = sel_err_r;
endmodule

// File: tb/tb_esm_dispatch_buffer.sv
// Self-checking bench for esm_dispatch_buffer: directed scenarios plus random traffic
// compared every cycle against a slot/queue level behavioural model.
module tb_esm_dispatch_buffer;
    localparam int BS = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          ready_valid;
    logic [3:0]    ready_index;
    logic          sel_valid = 1'b0;
    logic [3:0]    sel_index = '0;
    logic          sel_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          sel_err;

    int n_checks = 0;
    int n_errors = 0;

    esm_dispatch_buffer #(.bs(BS), .dw(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ready_valid(ready_valid), .ready_index(ready_index),
        .sel_valid(sel_valid), .sel_index(sel_index), .sel_ready(sel_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: slot table plus a queue of indices waiting to be announced.
    logic          m_occ [BS];
    logic [DW-1:0] m_mem [BS];
    int            m_q [$];
    logic          m_ready_valid;
    int            m_ready_index;
    logic          m_out_valid;
    logic [DW-1:0] m_out_data;
    logic          m_sel_err;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < BS; i++) if (m_occ[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) m_occ[i] = 1'b0;
        m_q.delete();
        m_ready_valid = 1'b0;
        m_ready_index = 0;
        m_out_valid   = 1'b0;
        m_out_data    = '0;
        m_sel_err     = 1'b0;
    endtask

    task automatic model_edge();
        bit acc, take, rel, err;
        int target = -1;
        acc  = in_valid && (m_count() < BS);
        for (int i = BS - 1; i >= 0; i--) if (!m_occ[i]) target = i;
        take = sel_valid && (!m_out_valid || out_ready);
        rel  = take && m_occ[sel_index];
        err  = take && !m_occ[sel_index];
        if (m_q.size() > 0) begin
            m_ready_valid = 1'b1;
            m_ready_index = m_q.pop_front();
        end else begin
            m_ready_valid = 1'b0;
        end
        if (rel) begin
            m_out_data  = m_mem[sel_index];
            m_out_valid = 1'b1;
            m_occ[sel_index] = 1'b0;
        end else if (out_ready) begin
            m_out_valid = 1'b0;
        end
        if (acc) begin
            m_mem[target] = in_data;
            m_occ[target] = 1'b1;
            m_q.push_back(target);
        end
        if (err) m_sel_err = 1'b1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int c = m_count();
        check("count", 64'(count), 64'(c));
        check("full", 64'(full), 64'(c == BS));
        check("empty", 64'(empty), 64'(c == 0));
        check("in_ready", 64'(in_ready), 64'(c != BS));
        check("sel_ready", 64'(sel_ready), 64'(!m_out_valid || out_ready));
        check("ready_valid", 64'(ready_valid), 64'(m_ready_valid));
        if (m_ready_valid) check("ready_index", 64'(ready_index), 64'(m_ready_index));
        check("out_valid", 64'(out_valid), 64'(m_out_valid));
        check("out_data", 64'(out_data), 64'(m_out_data));
        check("sel_err", 64'(sel_err), 64'(m_sel_err));
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] id, input logic sv,
                        input logic [3:0] si, input logic orr);
        @(negedge clk);
        in_valid = iv; in_data = id; sel_valid = sv; sel_index = si; out_ready = orr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input logic orr);
        step(1'b0, '0, 1'b0, 4'd0, orr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; sel_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_ready_index", 64'(ready_index), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;

        // Three accepts, indices announced one cycle later in order.
        do_reset();
        step(1'b1, 32'hA0, 1'b0, 4'd0, 1'b0);
        check("lit_first_rv", 64'(ready_valid), 64'd0);
        step(1'b1, 32'hA1, 1'b0, 4'd0, 1'b0);
        check("lit_ri0", 64'(ready_index), 64'd0);
        step(1'b1, 32'hA2, 1'b0, 4'd0, 1'b0);
        check("lit_ri1", 64'(ready_index), 64'd1);
        idle(1'b0);
        check("lit_ri2", 64'(ready_index), 64'd2);
        check("lit_cnt3", 64'(count), 64'd3);
        check("lit_empty0", 64'(empty), 64'd0);

        // Fill to full, release slot 5, reallocate slot 5.
        for (int i = 0; i < 13; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 4'd0, 1'b0);
        idle(1'b0);
        check("lit_full", 64'(full), 64'd1);
        check("lit_in_ready0", 64'(in_ready), 64'd0);
        step(1'b1, 32'hEE, 1'b1, 4'd5, 1'b1);
        check("lit_out5", 64'(out_data), 64'hB2);
        check("lit_in_ready1", 64'(in_ready), 64'd1);
        step(1'b1, 32'hC5, 1'b0, 4'd0, 1'b1);
        idle(1'b1);
        check("lit_realloc5", 64'(ready_index), 64'd5);

        // Back-pressured output stalls a second selection.
        step(1'b0, '0, 1'b1, 4'd2, 1'b0);
        check("lit_out2", 64'(out_data), 64'hA2);
        step(1'b0, '0, 1'b1, 4'd7, 1'b0);
        check("lit_sel_ready0", 64'(sel_ready), 64'd0);
        check("lit_cnt15", 64'(count), 64'd15);
        step(1'b0, '0, 1'b1, 4'd7, 1'b1);
        check("lit_out7", 64'(out_data), 64'hB4);
        check("lit_cnt14", 64'(count), 64'd14);
        idle(1'b1);

        // Selecting a freed slot raises the sticky error.
        step(1'b0, '0, 1'b1, 4'd9, 1'b1);
        idle(1'b1);
        step(1'b0, '0, 1'b1, 4'd9, 1'b1);
        check("lit_sel_err", 64'(sel_err), 64'd1);
        check("lit_err_cnt", 64'(count), 64'd13);
        check("lit_err_ov", 64'(out_valid), 64'd0);
        idle(1'b1);
        check("lit_err_sticky", 64'(sel_err), 64'd1);

        // Accept and release in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 4'd0, 1'b1);
        step(1'b0, '0, 1'b1, 4'd3, 1'b1);
        idle(1'b1);
        step(1'b1, 32'hF0, 1'b1, 4'd1, 1'b1);
        check("lit_same_cnt", 64'(count), 64'd3);
        check("lit_same_out", 64'(out_data), 64'hE1);
        idle(1'b1);
        check("lit_same_ri", 64'(ready_index), 64'd3);

        // Asynchronous reset in the middle of a transfer.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h55; sel_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("lit_rst_cnt", 64'(count), 64'd0);
        check("lit_rst_in_ready", 64'(in_ready), 64'd1);
        check("lit_rst_ov", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("lit_rst_quiet", 64'(ready_valid), 64'd0);
        step(1'b1, 32'h77, 1'b0, 4'd0, 1'b0);
        idle(1'b0);
        check("lit_rst_slot0", 64'(ready_index), 64'd0);
        check("lit_rst_rv", 64'(ready_valid), 64'd1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < 60), $urandom(),
                     1'($urandom_range(0, 99) < 55), 4'($urandom_range(0, BS - 1)),
                     1'($urandom_range(0, 99) < 70));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
